// File: rtl/fp_pkg.sv
// fp_pkg: shared types, default sizes and sizing checks for the forward-propagation engine.
//   fp_state_t : controller states IDLE, MAC, DRAIN, WRITE, DONE
//   *_DEF      : default layer geometry and datapath widths
//   PIX_AW, W_AW, CLS_W : address/index widths for the default geometry
//   acc_w_ok() : true when an accumulator width cannot overflow over a full dot product
package fp_pkg;
    typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} fp_state_t;
    localparam int IMG_SIZE_DEF = 256;
    localparam int CLASSES_DEF  = 10;
    localparam int PIX_W_DEF    = 8;
    localparam int WGT_W_DEF    = 8;
    localparam int ACC_W_DEF    = 24;
    localparam int PIX_AW = $clog2(IMG_SIZE_DEF);
    localparam int W_AW   = $clog2(IMG_SIZE_DEF * CLASSES_DEF);
    localparam int CLS_W  = $clog2(CLASSES_DEF);
    function automatic bit acc_w_ok(int acc_w, int pix_w, int wgt_w, int img);
        return acc_w >= pix_w + wgt_w + $clog2(img);
    endfunction
endpackage

// File: rtl/forprop_engine_mac_unit.sv
// mac_unit: registered signed multiply-accumulate of an unsigned pixel and a signed weight.
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : zero the accumulator (wins over en_i)
//   en_i       : add pixel_i * weight_i to the accumulator
//   pixel_i    : unsigned pixel, zero-extended before the multiply
//   weight_i   : two's-complement weight
//   acc_o      : signed running sum
module mac_unit #(
    parameter int PIX_W = 8,
    parameter int WGT_W = 8,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic [PIX_W-1:0]        pixel_i,
    input  logic [WGT_W-1:0]        weight_i,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [PIX_W+WGT_W:0] prod;
    logic signed [ACC_W-1:0]     acc_q;
    assign prod  = $signed({1'b0, pixel_i}) * $signed(weight_i);
    assign acc_o = acc_q;
    always_ff @(posedge clk) begin
        if (reset || clear_i) acc_q <= '0;
        else if (en_i)        acc_q <= acc_q + ACC_W'(prod);
    end
endmodule

// File: rtl/forprop_engine.sv
// forprop_engine: dense-layer forward pass streaming pixel/weight RAMs through one MAC, with argmax.
//   clk, reset     : clock, synchronous active-high reset
//   start_forprop  : level run request; forprop_done held until it drops
//   pix_re/addr    : pixel RAM read port, pix_data valid one cycle later
//   w_re/addr      : weight RAM read port (n*IMG_SIZE+i), w_data valid one cycle later
//   score_we/addr/data : one signed score per neuron
//   pred_class     : argmax of the last completed run (ties keep the lower index)
module forprop_engine
    import fp_pkg::*;
#(
    parameter int IMG_SIZE = IMG_SIZE_DEF,
    parameter int CLASSES  = CLASSES_DEF,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int WGT_W    = WGT_W_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_forprop,
    output logic                            forprop_done,
    output logic                            pix_re,
    output logic [$clog2(IMG_SIZE)-1:0]     pix_addr,
    input  logic [PIX_W-1:0]                pix_data,
    output logic                            w_re,
    output logic [$clog2(IMG_SIZE*CLASSES)-1:0] w_addr,
    input  logic [WGT_W-1:0]                w_data,
    output logic                            score_we,
    output logic [$clog2(CLASSES)-1:0]      score_addr,
    output logic [ACC_W-1:0]                score_data,
    output logic [$clog2(CLASSES)-1:0]      pred_class
);
    localparam int PAW = $clog2(IMG_SIZE);
    localparam int WAW = $clog2(IMG_SIZE * CLASSES);
    localparam int CW  = $clog2(CLASSES);

    if (!acc_w_ok(ACC_W, PIX_W, WGT_W, IMG_SIZE)) begin : g_acc_w_check
        $error("forprop_engine: ACC_W too narrow for IMG_SIZE/PIX_W/WGT_W");
    end

    fp_state_t               state_q, state_d;
    logic [CW-1:0]           n_q, n_d, max_idx_q, max_idx_d, pred_q, pred_d;
    logic [PAW-1:0]          i_q, i_d;
    logic                    v_q, v_d, done_q, clear;
    logic signed [ACC_W-1:0] acc, max_score_q, max_score_d;
    logic                    better;

    mac_unit #(.PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) u_mac (
        .clk(clk), .reset(reset), .clear_i(clear), .en_i(v_q),
        .pixel_i(pix_data), .weight_i(w_data), .acc_o(acc)
    );

    // Addresses come straight from (n,i), which stay frozen outside MAC, so they hold.
    assign pix_addr     = i_q;
    assign w_addr       = WAW'(n_q) * WAW'(IMG_SIZE) + WAW'(i_q);
    assign score_addr   = n_q;
    assign score_data   = acc;
    assign pred_class   = pred_q;
    assign forprop_done = done_q;
    assign better       = (n_q == '0) || (acc > max_score_q);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        i_d         = i_q;
        v_d         = v_q;
        max_score_d = max_score_q;
        max_idx_d   = max_idx_q;
        pred_d      = pred_q;
        clear       = 1'b0;
        pix_re      = 1'b0;
        w_re        = 1'b0;
        score_we    = 1'b0;
        case (state_q)
            IDLE: if (start_forprop) begin
                state_d = MAC;
                n_d     = '0;
                i_d     = '0;
                v_d     = 1'b0;
                clear   = 1'b1;
            end
            MAC: begin
                pix_re = 1'b1;
                w_re   = 1'b1;
                v_d    = 1'b1;
                if (i_q == PAW'(IMG_SIZE - 1)) state_d = DRAIN;
                else                           i_d = i_q + 1'b1;
            end
            DRAIN: begin
                v_d     = 1'b0;
                state_d = WRITE;
            end
            WRITE: begin
                score_we = 1'b1;
                if (better) begin
                    max_score_d = acc;
                    max_idx_d   = n_q;
                end
                if (n_q == CW'(CLASSES - 1)) begin
                    state_d = DONE;
                    // Fold in this neuron's comparison, since max_idx_q updates on the same edge.
                    pred_d  = better ? n_q : max_idx_q;
                end else begin
                    state_d = MAC;
                    n_d     = n_q + 1'b1;
                    i_d     = '0;
                    clear   = 1'b1;
                end
            end
            DONE: if (!start_forprop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            i_q         <= '0;
            v_q         <= 1'b0;
            max_score_q <= '0;
            max_idx_q   <= '0;
            pred_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            i_q         <= i_d;
            v_q         <= v_d;
            max_score_q <= max_score_d;
            max_idx_q   <= max_idx_d;
            pred_q      <= pred_d;
            // Registered so done rises one cycle into DONE and falls one cycle after leaving it.
            done_q      <= (state_q == DONE);
        end
    end
endmodule

// File: tb/tb_forprop_engine.sv
// tb_forprop_engine: directed self-checking bench for forprop_engine with behavioural pixel/weight RAMs.
module tb_forprop_engine;
    import fp_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start_forprop = 1'b0;
    logic              forprop_done, pix_re, w_re, score_we;
    logic [PIX_AW-1:0] pix_addr;
    logic [W_AW-1:0]   w_addr;
    logic [7:0]        pix_data, w_data;
    logic [CLS_W-1:0]  score_addr, pred_class;
    logic [23:0]       score_data;

    logic [7:0] pix_mem [256];
    logic [7:0] w_mem   [2560];
    int         sc_addr [32];
    int         sc_data [32];
    int         ns;
    int         checks = 0;
    int         failures = 0;

    forprop_engine dut (
        .clk(clk), .reset(reset), .start_forprop(start_forprop), .forprop_done(forprop_done),
        .pix_re(pix_re), .pix_addr(pix_addr), .pix_data(pix_data),
        .w_re(w_re), .w_addr(w_addr), .w_data(w_data),
        .score_we(score_we), .score_addr(score_addr), .score_data(score_data),
        .pred_class(pred_class)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pix_re) pix_data <= pix_mem[pix_addr];
        if (w_re)   w_data   <= w_mem[w_addr];
    end

    always @(negedge clk) begin
        if (score_we) begin
            if (ns < 32) begin
                sc_addr[ns] = int'(score_addr);
                sc_data[ns] = int'($signed(score_data));
            end
            ns = ns + 1;
        end
    end

    task automatic fill(input int pix, input int wsel);
        for (int i = 0; i < 256; i++) pix_mem[i] = 8'(pix);
        for (int n = 0; n < 10; n++)
            for (int i = 0; i < 256; i++)
                case (wsel)
                    0: w_mem[n*256+i] = 8'(n);
                    1: w_mem[n*256+i] = (n == 3) ? 8'h01 : 8'hFF;
                    default: w_mem[n*256+i] = 8'h80;
                endcase
    endtask

    // Raise start, count edges after the sampling edge until done is seen (5000 means timeout).
    task automatic run_forprop(output int lat);
        @(negedge clk);
        ns = 0;
        start_forprop = 1'b1;
        @(posedge clk);
        lat = 5000;
        for (int k = 1; k < 5000; k++) begin
            @(posedge clk);
            #1;
            if (forprop_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic drop_start;
        @(negedge clk);
        start_forprop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_scores(input string name, input int exp_pred, input int e0, input int e_step, input int e_special, input int sp_idx);
        int e;
        checks++;
        if (ns !== 10) begin
            failures++;
            $display("FAIL %s score_count got=%0d exp=10", name, ns);
        end
        for (int n = 0; n < 10; n++) begin
            e = (n == sp_idx) ? e_special : e0 + n * e_step;
            checks++;
            if (sc_addr[n] !== n || sc_data[n] !== e) begin
                failures++;
                $display("FAIL %s score[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", name, n, sc_addr[n], sc_data[n], n, e);
            end
        end
        checks++;
        if (pred_class !== CLS_W'(exp_pred)) begin
            failures++;
            $display("FAIL %s pred_class got=%0d exp=%0d", name, pred_class, exp_pred);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start_forprop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({forprop_done, pix_re, w_re, score_we, pix_addr, w_addr, score_addr, score_data, pred_class} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got done=%b pre=%b wre=%b we=%b pa=%0d wa=%0d sa=%0d sd=%0d pc=%0d exp all 0",
                     forprop_done, pix_re, w_re, score_we, pix_addr, w_addr, score_addr, score_data, pred_class);
        end
        @(negedge clk);
        reset = 1'b0;
        start_forprop = 1'b0;
        ns = 0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (pix_re !== 1'b0 || w_re !== 1'b0 || forprop_done !== 1'b0 || ns !== 0) begin
            failures++;
            $display("FAIL reset_idle got pre=%b wre=%b done=%b writes=%0d exp 0 0 0 0", pix_re, w_re, forprop_done, ns);
        end
    endtask

    task automatic test_ramp(input string name);
        int lat;
        fill(1, 0);
        run_forprop(lat);
        checks++;
        if (lat !== 2581) begin
            failures++;
            $display("FAIL %s done_latency got=%0d exp=2581", name, lat);
        end
        check_scores(name, 9, 0, 256, 0, 0);
        drop_start();
    endtask

    task automatic test_signed;
        int lat;
        fill(255, 1);
        run_forprop(lat);
        check_scores("signed", 3, -65280, 0, 65280, 3);
        drop_start();
    endtask

    task automatic test_extreme_tie;
        int lat;
        fill(255, 2);
        run_forprop(lat);
        check_scores("extreme_tie", 0, -8355840, 0, -8355840, 0);
        drop_start();
    endtask

    task automatic test_abort;
        int seen_done = 0;
        fill(1, 0);
        @(negedge clk);
        start_forprop = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start_forprop = 1'b0;
        ns = 0;
        #1;
        checks++;
        if (pred_class !== '0) begin
            failures++;
            $display("FAIL abort_pred_clear got=%0d exp=0", pred_class);
        end
        for (int k = 0; k < 2700; k++) begin
            @(posedge clk);
            #1;
            if (forprop_done) seen_done++;
        end
        checks++;
        if (ns !== 0 || seen_done !== 0) begin
            failures++;
            $display("FAIL abort_quiet got writes=%0d done_cycles=%0d exp 0 0", ns, seen_done);
        end
        test_ramp("abort_rerun");
    endtask

    task automatic test_handshake;
        int lat, reads = 0, low_done = 0;
        fill(1, 0);
        run_forprop(lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (pix_re || w_re) reads++;
            if (!forprop_done) low_done++;
        end
        checks++;
        if (reads !== 0 || low_done !== 0) begin
            failures++;
            $display("FAIL handshake_hold got reads=%0d done_low_cycles=%0d exp 0 0", reads, low_done);
        end
        drop_start();
        checks++;
        if (forprop_done !== 1'b0 || pix_re !== 1'b0) begin
            failures++;
            $display("FAIL handshake_release got done=%b pre=%b exp 0 0", forprop_done, pix_re);
        end
        ns = 0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (pix_re !== 1'b0 || ns !== 0 || pred_class !== CLS_W'(9)) begin
            failures++;
            $display("FAIL handshake_idle got pre=%b writes=%0d pred=%0d exp 0 0 9", pix_re, ns, pred_class);
        end
    endtask

    initial begin
        ns = 0;
        test_reset();
        test_ramp("ramp");
        test_abort();
        test_signed();
        test_extreme_tie();
        test_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/forprop_engine.md
Name: forprop_engine

Overview:
- Forward-propagation datapath for a single dense layer: IMG_SIZE pixel inputs, CLASSES output neurons.
- Started by the NN controller's start_forprop level; returns forprop_done to it.
- Streams pixels and weights from synchronous RAMs through one signed MAC.
- Writes one score per neuron to the score buffer, which backprop and display consume, and produces the argmax class.

Parameters:
- IMG_SIZE, 256, pixels per image (inputs per neuron).
- CLASSES, 10, output neurons.
- PIX_W, 8, unsigned pixel width.
- WGT_W, 8, signed two's-complement weight width.
- ACC_W, 24, signed accumulator/score width; must be at least PIX_W+WGT_W+$clog2(IMG_SIZE).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start_forprop  in  1  level request from controller
- forprop_done  out  1  run complete; held until start_forprop is low
- pix_re  out  1  pixel RAM read enable
- pix_addr  out  $clog2(IMG_SIZE)  pixel index i
- pix_data  in  PIX_W  pixel RAM data, valid 1 cycle after pix_re
- w_re  out  1  weight RAM read enable
- w_addr  out  $clog2(IMG_SIZE*CLASSES)  weight address = n*IMG_SIZE+i
- w_data  in  WGT_W  weight RAM data, valid 1 cycle after w_re
- score_we  out  1  score write strobe
- score_addr  out  $clog2(CLASSES)  neuron index n
- score_data  out  ACC_W  signed neuron score
- pred_class  out  $clog2(CLASSES)  argmax of the last completed run

Behaviour:
- Reset values:
  - All outputs 0, state IDLE.
  - n, i, acc, max_score, max_idx and the data-valid flag v all cleared.
- Reset mid-run: abort immediately to IDLE. No further score_we. pred_class cleared to 0.
- State IDLE:
  - On start_forprop=1: n<=0, i<=0, acc<=0, v<=0, go to MAC.
- State MAC:
  - pix_re=w_re=1; addresses driven from (n,i); v<=1.
  - If v=1: acc <= acc + signed({0,pix_data}) * signed(w_data).
  - If i==IMG_SIZE-1, go to DRAIN; else i++.
- State DRAIN:
  - Read enables 0; accumulate the final product; v<=0; go to WRITE.
- State WRITE:
  - score_we=1, score_addr=n, score_data=acc.
  - Argmax update: if n==0, or acc > max_score (strict, signed), then max_score<=acc and max_idx<=n. Ties keep the lower index.
  - If n==CLASSES-1, go to DONE.
  - Else n++, i<=0, acc<=0, go to MAC.
- State DONE:
  - forprop_done=1. pred_class<=max_idx on entry to DONE; held until the next DONE entry or reset.
  - If start_forprop==0, go to IDLE; done falls the next cycle.
  - A start_forprop still high in DONE never retriggers a run. A new run needs a pass through IDLE with start_forprop=1.
- Latency:
  - Each neuron takes IMG_SIZE+2 cycles (MAC×IMG_SIZE, DRAIN, WRITE).
  - forprop_done rises CLASSES*(IMG_SIZE+2)+1 cycles after the clk edge that samples start in IDLE. Default: 2581.
- Arithmetic:
  - Pixels zero-extended; products sign-extended to ACC_W.
  - No saturation; ACC_W sizing guarantees no overflow.
- start_forprop dropping during MAC/DRAIN/WRITE is ignored; the run completes.
- Address ports hold their last value when the read enables are 0.

Decomposition:
- Package fp_pkg:
  - state enum fp_state_t {IDLE, MAC, DRAIN, WRITE, DONE}.
  - Width localparams (PIX_AW, W_AW, CLS_W).
  - Helper function for the ACC_W minimum check, used by a static assertion.
- Sub-module mac_unit:
  - Inputs: clear, en, pixel, weight. Output: acc.
  - Signed multiply-accumulate, registered.

Test Plan:
- Reset: assert reset 3 cycles with start high → all outputs 0 and no read enables. Release with start=0 → stays IDLE.
- Ramp: pixels all 1, neuron n weights all n → score_data n*256 written at addr n in order. pred_class=9. done at cycle 2581.
- Signed: pixels 255, neuron 3 weights +1, others −1 → score3=65280, others −65280, pred_class=3.
- Extreme/tie: pixels 255, all weights −128 → every score −8355840 with no overflow, pred_class=0 (tie, lowest index).
- Abort: reset pulse at cycle 100 of a run → no score_we afterwards, done=0. A fresh start then reproduces the ramp result exactly.
- Handshake: hold start high 5 cycles after done → done stays 1 and no new reads occur. Drop start → done=0 the next cycle, state IDLE.
